// File: rtl/pc_pkg.sv
// pc_pkg: shared program-counter definitions for the fetch stage.
//   PC_WIDTH  default PC/address width in bits
//   PC_INC    default sequential increment in bytes (one 32-bit instruction)
//   pc_t      PC/address type
//   PC_RESET  value the PC+INC register takes on reset
package pc_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_INC   = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET = '0;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// pc_adder: combinational unsigned WIDTH-bit adder with carry-out.
// Ports:
//   a    in  WIDTH  first operand
//   b    in  WIDTH  second operand
//   sum  out WIDTH  (a + b) mod 2^WIDTH
//   cout out 1      carry out of the WIDTH-bit addition
module pc_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule : pc_adder

// File: rtl/somador_pc4.sv
// somador_pc4: registered program-counter incrementer for the fetch stage.
// Samples PC each rising edge and presents PC+INC one cycle later, plus a
// registered carry flag marking address wrap-around.
// Ports:
//   clock       in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   PC          in   WIDTH  current program counter (byte address)
//   PC4         out  WIDTH  registered PC + INC (modulo 2^WIDTH)
//   wrap        out  1      registered carry-out of PC + INC
//   misaligned  out  1      registered (PC[1:0] != 0); present only when
//                           SOMADOR_PC4_ALIGN_CHECK_EN is defined
// Configuration macro: SOMADOR_PC4_ALIGN_CHECK_EN
module somador_pc4
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned INC   = PC_INC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic             wrap
`ifdef SOMADOR_PC4_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  logic [WIDTH-1:0] sum;
  logic             cout;

  logic [WIDTH-1:0] pc4_q,  pc4_d;
  logic             wrap_q, wrap_d;

  pc_adder #(
    .WIDTH (WIDTH)
  ) u_pc_adder (
    .a    (PC),
    .b    (WIDTH'(INC)),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    pc4_d  = sum;
    wrap_d = cout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc4_q  <= WIDTH'(PC_RESET);
      wrap_q <= 1'b0;
    end else begin
      pc4_q  <= pc4_d;
      wrap_q <= wrap_d;
    end
  end

  assign PC4  = pc4_q;
  assign wrap = wrap_q;

`ifdef SOMADOR_PC4_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = (PC[1:0] != 2'b00);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`endif

endmodule : somador_pc4

// File: tb/tb_somador_pc4.sv
// tb_somador_pc4: self-checking bench for somador_pc4.
// Directed scenarios plus randomized PC/reset stimulus, each checked against
// a plain-arithmetic reference: result = PC + 4 computed in 64 bits, low 32
// bits compared with PC4 and bit 32 with wrap.
// Honours SOMADOR_PC4_ALIGN_CHECK_EN to exercise the misaligned output.
module tb_somador_pc4;

  logic        clock;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        wrap;
`ifdef SOMADOR_PC4_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  somador_pc4 #(
    .WIDTH (32),
    .INC   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .PC    (PC),
    .PC4   (PC4),
    .wrap  (wrap)
`ifdef SOMADOR_PC4_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply reset/PC for one rising edge, then compare all outputs against the
  // arithmetic reference just after that edge.
  task automatic apply(input string tag, input bit r, input logic [31:0] p);
    longint unsigned total;
    logic [31:0]     exp_pc4;
    logic            exp_wrap;
    reset = r;
    PC    = p;
    @(posedge clock);
    #1;
    total    = longint'(p) + 64'd4;
    exp_pc4  = r ? 32'h0 : total[31:0];
    exp_wrap = r ? 1'b0  : total[32];
    check({tag, ".PC4"},  {32'h0, PC4},  {32'h0, exp_pc4});
    check({tag, ".wrap"}, {63'h0, wrap}, {63'h0, exp_wrap});
`ifdef SOMADOR_PC4_ALIGN_CHECK_EN
    check({tag, ".mis"}, {63'h0, misaligned}, {63'h0, (!r && (p % 4 != 0))});
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    PC       = 32'h40;
    @(negedge clock);

    // Reset held for two edges, PC ignored.
    apply("rst0", 1'b1, 32'h40);
    apply("rst1", 1'b1, 32'h40);
    apply("rel",  1'b0, 32'h40);

    // Sequential addresses, one per edge.
    for (int unsigned i = 1; i <= 4; i++) begin
      apply("seq", 1'b0, 32'(i * 4));
    end

    // Hold with a glitch between edges that must not reach PC4.
    apply("hold0", 1'b0, 32'h100);
    PC = 32'hDEAD_BEE0;
    #2;
    check("glitch.PC4", {32'h0, PC4}, 64'h104);
    PC = 32'h100;
    apply("hold1", 1'b0, 32'h100);
    apply("hold2", 1'b0, 32'h100);

    // Wrap-around boundary.
    apply("wrapFC", 1'b0, 32'hFFFF_FFFC);
    apply("wrap0",  1'b0, 32'h0);
    apply("wrapFF", 1'b0, 32'hFFFF_FFFF);

    // Mid-run reset.
    apply("run20",  1'b0, 32'h20);
    apply("mrst",   1'b1, 32'h20);
    apply("mrel",   1'b0, 32'h20);

    // Alignment cases (misaligned is checked inside apply when enabled).
    apply("al6", 1'b0, 32'h6);
    apply("al8", 1'b0, 32'h8);

    // Randomized: mix of arbitrary, near-wrap and small values, rare resets.
    for (int unsigned i = 0; i < 300; i++) begin
      logic [31:0] p;
      bit          r;
      case ($urandom_range(0, 3))
        0:       p = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       p = 32'($urandom_range(0, 64));
        default: p = $urandom;
      endcase
      r = ($urandom_range(0, 15) == 0);
      apply("rnd", r, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_somador_pc4
